// File: rtl/decode_inst_queue.sv
// -----------------------------------------------------------------------------
// decode_inst_queue
//
// Multi-lane instruction buffer sitting between Fetch and Decode. Up to LANES
// instructions are written per cycle (valid lanes compacted in lane order) and
// up to LANES of the oldest entries are presented, in order, to Decode with
// zero-latency first-word-fall-through. A syscall is only ever released alone
// in lane 0, after which dequeue is held off for SYS_BUBBLES non-stalled
// cycles. Flush_IN discards the whole queue and any pending bubble window.
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RESET          asynchronous active-low reset
//   Enq_Valid_IN   per-lane valid from Fetch
//   Enq_Instr_IN   per-lane instruction, lane k at [32k+31:32k]
//   Enq_PC_IN      per-lane PC, same packing
//   Enq_Ready_OUT  room for a full LANES group (registered count only)
//   Deq_Valid_OUT  per-lane valid to Decode, contiguous from lane 0
//   Deq_Instr_OUT  head instructions, lane 0 oldest, 0 on invalid lanes
//   Deq_PC_OUT     head PCs, 0 on invalid lanes
//   Deq_Ready_IN   Decode takes every valid lane
//   STALL_IN       back-end stall, blocks dequeue and freezes the bubble count
//   Flush_IN       synchronous flush of the whole queue
//   Count_OUT      current occupancy
//   SYS_Hold_OUT   syscall bubble window active
// -----------------------------------------------------------------------------
module decode_inst_queue #(
  parameter int DEPTH       = 8,
  parameter int LANES       = 2,
  parameter int SYS_BUBBLES = 4,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [LANES-1:0]      Enq_Valid_IN,
  input  logic [32*LANES-1:0]   Enq_Instr_IN,
  input  logic [32*LANES-1:0]   Enq_PC_IN,
  output logic                  Enq_Ready_OUT,
  output logic [LANES-1:0]      Deq_Valid_OUT,
  output logic [32*LANES-1:0]   Deq_Instr_OUT,
  output logic [32*LANES-1:0]   Deq_PC_OUT,
  input  logic                  Deq_Ready_IN,
  input  logic                  STALL_IN,
  input  logic                  Flush_IN,
  output logic [CNT_W-1:0]      Count_OUT,
  output logic                  SYS_Hold_OUT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BUB_W = 3;
  localparam logic [31:0] SYSCALL = 32'h0000_000c;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BUB_W-1:0] bub_q, bub_d;

  // Payload storage; contents are meaningless outside head..head+count-1, so
  // it carries no reset.
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];

  function automatic logic [CNT_W-1:0] popcnt(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Enqueue side
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] free_slots;
  logic             enq_ready;
  logic             enq_fire;
  logic [CNT_W-1:0] enq_n;
  logic [PTR_W-1:0] enq_addr [LANES];
  logic [LANES-1:0] enq_we;

  // Ready looks only at the registered count: a pop in the same cycle does
  // not lend its slots to Fetch.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign enq_ready  = (free_slots >= CNT_W'(LANES));
  assign enq_fire   = enq_ready && !Flush_IN;
  assign enq_n      = enq_fire ? popcnt(Enq_Valid_IN) : '0;

  // Each valid lane lands at tail plus the number of valid lanes below it,
  // which squeezes holes out of a sparse valid mask.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int k = 0; k < LANES; k++) begin
      enq_addr[k] = tail_q + off;
      enq_we[k]   = enq_fire && Enq_Valid_IN[k];
      off         = off + PTR_W'(Enq_Valid_IN[k]);
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < LANES; k++) begin
      if (enq_we[k]) begin
        instr_mem_q[enq_addr[k]] <= Enq_Instr_IN[32*k +: 32];
        pc_mem_q[enq_addr[k]]    <= Enq_PC_IN[32*k +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dequeue side (combinational view of the head window)
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rd_addr  [LANES];
  logic [31:0]      rd_instr [LANES];
  logic [31:0]      rd_pc    [LANES];
  logic [LANES-1:0] rd_sys;
  logic [LANES-1:0] deq_valid;
  logic             pop;
  logic [CNT_W-1:0] deq_n;
  logic             sys_pop;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
    assign rd_addr[gi]  = head_q + PTR_W'(gi);
    assign rd_instr[gi] = instr_mem_q[rd_addr[gi]];
    assign rd_pc[gi]    = pc_mem_q[rd_addr[gi]];
    assign rd_sys[gi]   = (rd_instr[gi] == SYSCALL);

    assign Deq_Instr_OUT[32*gi +: 32] = deq_valid[gi] ? rd_instr[gi] : 32'h0;
    assign Deq_PC_OUT[32*gi +: 32]    = deq_valid[gi] ? rd_pc[gi]    : 32'h0;
  end

  // A lane is offered only if it is occupied, no bubble window is running,
  // no older lane in the window is a syscall, and it is not itself a syscall
  // sitting behind lane 0. Together this keeps the valid mask a prefix and
  // isolates every syscall in lane 0.
  always_comb begin
    logic sys_ahead;
    sys_ahead = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      deq_valid[k] = (CNT_W'(k) < count_q) && (bub_q == '0) && !sys_ahead &&
                     (!rd_sys[k] || (k == 0));
      sys_ahead    = sys_ahead || rd_sys[k];
    end
  end

  // Flush wins over everything: the flush cycle still shows the old head but
  // never consumes it.
  assign pop     = Deq_Ready_IN && !STALL_IN && !Flush_IN;
  assign deq_n   = pop ? popcnt(deq_valid) : '0;
  assign sys_pop = pop && deq_valid[0] && rd_sys[0];

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    bub_d   = bub_q;
    if (Flush_IN) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      bub_d   = '0;
    end else begin
      // DEPTH is a power of two, so truncating the sum is the wrap.
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
      // A syscall can only pop while the counter is idle, so loading and
      // counting down never collide.
      if (bub_q != '0) begin
        if (!STALL_IN) begin
          bub_d = bub_q - BUB_W'(1);
        end
      end else if (sys_pop) begin
        bub_d = BUB_W'(SYS_BUBBLES);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      bub_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      bub_q   <= bub_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Enq_Ready_OUT = enq_ready;
  assign Deq_Valid_OUT = deq_valid;
  assign Count_OUT     = count_q;
  assign SYS_Hold_OUT  = (bub_q != '0);

endmodule

// File: tb/tb_decode_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_inst_queue
//
// Directed bench for decode_inst_queue (DEPTH=8, LANES=2, SYS_BUBBLES=4).
// A queue-based reference model tracks the buffered instructions and the
// bubble window; a compare process checks every DUT output against it on each
// falling edge (and right after an asynchronous reset edge). The stimulus can
// additionally pin one hand-computed literal value per cycle, which the same
// compare process checks.
// -----------------------------------------------------------------------------
module tb_decode_inst_queue;

  localparam int DEPTH       = 8;
  localparam int LANES       = 2;
  localparam int SYS_BUBBLES = 4;
  localparam int CNT_W       = $clog2(DEPTH) + 1;
  localparam logic [31:0] SYS  = 32'h0000_000c;
  localparam logic [31:0] ADDU = 32'h0022_1821;

  logic                CLK;
  logic                RESET;
  logic [LANES-1:0]    Enq_Valid_IN;
  logic [32*LANES-1:0] Enq_Instr_IN;
  logic [32*LANES-1:0] Enq_PC_IN;
  logic                Enq_Ready_OUT;
  logic [LANES-1:0]    Deq_Valid_OUT;
  logic [32*LANES-1:0] Deq_Instr_OUT;
  logic [32*LANES-1:0] Deq_PC_OUT;
  logic                Deq_Ready_IN;
  logic                STALL_IN;
  logic                Flush_IN;
  logic [CNT_W-1:0]    Count_OUT;
  logic                SYS_Hold_OUT;

  decode_inst_queue #(
    .DEPTH(DEPTH), .LANES(LANES), .SYS_BUBBLES(SYS_BUBBLES)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .Enq_Valid_IN(Enq_Valid_IN), .Enq_Instr_IN(Enq_Instr_IN), .Enq_PC_IN(Enq_PC_IN),
    .Enq_Ready_OUT(Enq_Ready_OUT),
    .Deq_Valid_OUT(Deq_Valid_OUT), .Deq_Instr_OUT(Deq_Instr_OUT), .Deq_PC_OUT(Deq_PC_OUT),
    .Deq_Ready_IN(Deq_Ready_IN), .STALL_IN(STALL_IN), .Flush_IN(Flush_IN),
    .Count_OUT(Count_OUT), .SYS_Hold_OUT(SYS_Hold_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and pinned literal expectation (stimulus-owned)
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  bit          pin_on  = 1'b0;
  int          pin_sel = 0;
  logic [31:0] pin_val = '0;
  string       pin_name = "";

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + compare process
  // ---------------------------------------------------------------------------
  ent_t mq[$];
  int   bub = 0;

  always begin : cmp
    int                  n;
    int                  npop;
    bit                  ok;
    bit                  sys_popped;
    bit                  exp_rdy;
    logic [LANES-1:0]    exp_val;
    logic [32*LANES-1:0] exp_i;
    logic [32*LANES-1:0] exp_p;
    ent_t                e;

    @(negedge CLK or negedge RESET);
    #1;
    if (!RESET) begin
      mq.delete();
      bub = 0;
      check("rst_enq_ready", Enq_Ready_OUT, 1);
      check("rst_deq_valid", Deq_Valid_OUT, 0);
      check("rst_deq_instr", Deq_Instr_OUT, 0);
      check("rst_deq_pc",    Deq_PC_OUT,    0);
      check("rst_count",     Count_OUT,     0);
      check("rst_sys_hold",  SYS_Hold_OUT,  0);
    end else begin
      n       = mq.size();
      exp_rdy = ((DEPTH - n) >= LANES);
      exp_val = '0;
      exp_i   = '0;
      exp_p   = '0;
      for (int k = 0; k < LANES; k++) begin
        ok = (k < n) && (bub == 0);
        if (ok) begin
          for (int j = 0; j < k; j++) begin
            if (mq[j].instr == SYS) ok = 1'b0;
          end
          if (k > 0 && mq[k].instr == SYS) ok = 1'b0;
        end
        if (ok) begin
          exp_val[k]        = 1'b1;
          exp_i[32*k +: 32] = mq[k].instr;
          exp_p[32*k +: 32] = mq[k].pc;
        end
      end

      check("enq_ready", Enq_Ready_OUT, exp_rdy);
      check("deq_valid", Deq_Valid_OUT, exp_val);
      check("deq_instr", Deq_Instr_OUT, exp_i);
      check("deq_pc",    Deq_PC_OUT,    exp_p);
      check("count",     Count_OUT,     n);
      check("sys_hold",  SYS_Hold_OUT,  (bub != 0));

      if (pin_on) begin
        case (pin_sel)
          0: check(pin_name, Count_OUT,          pin_val);
          1: check(pin_name, Enq_Ready_OUT,      pin_val);
          2: check(pin_name, Deq_Valid_OUT,      pin_val);
          3: check(pin_name, Deq_PC_OUT[31:0],   pin_val);
          4: check(pin_name, Deq_PC_OUT[63:32],  pin_val);
          5: check(pin_name, SYS_Hold_OUT,       pin_val);
          default: check(pin_name, Deq_Instr_OUT[31:0], pin_val);
        endcase
      end

      // Advance the model to the state after the coming rising edge.
      if (Flush_IN) begin
        mq.delete();
        bub = 0;
      end else begin
        sys_popped = 1'b0;
        if (Deq_Ready_IN && !STALL_IN) begin
          npop = 0;
          for (int k = 0; k < LANES; k++) npop += int'(exp_val[k]);
          for (int k = 0; k < npop; k++) begin
            if (mq[0].instr == SYS) sys_popped = 1'b1;
            mq.delete(0);
          end
        end
        if (bub > 0) begin
          if (!STALL_IN) bub--;
        end else if (sys_popped) begin
          bub = SYS_BUBBLES;
        end
        if (exp_rdy) begin
          for (int k = 0; k < LANES; k++) begin
            if (Enq_Valid_IN[k]) begin
              e.instr = Enq_Instr_IN[32*k +: 32];
              e.pc    = Enq_PC_IN[32*k +: 32];
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {16'h2400, pc[15:0]};
  endfunction

  task automatic pin(input int sel, input logic [31:0] v, input string nm);
    pin_on   = 1'b1;
    pin_sel  = sel;
    pin_val  = v;
    pin_name = nm;
  endtask

  task automatic cyc(input logic [1:0] ev,
                     input logic [31:0] i0, input logic [31:0] p0,
                     input logic [31:0] i1, input logic [31:0] p1,
                     input logic dr, input logic st, input logic fl);
    Enq_Valid_IN = ev;
    Enq_Instr_IN = {i1, i0};
    Enq_PC_IN    = {p1, p0};
    Deq_Ready_IN = dr;
    STALL_IN     = st;
    Flush_IN     = fl;
    @(posedge CLK);
    #1;
    pin_on = 1'b0;
  endtask

  task automatic idle(input logic dr, input logic st);
    cyc(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, dr, st, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    RESET        = 1'b0;
    Enq_Valid_IN = '0;
    Enq_Instr_IN = '0;
    Enq_PC_IN    = '0;
    Deq_Ready_IN = 1'b0;
    STALL_IN     = 1'b0;
    Flush_IN     = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Reset mid-traffic: five entries, then an asynchronous pulse between edges.
    cyc(2'b11, ins(32'h10), 32'h10, ins(32'h14), 32'h14, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, ins(32'h18), 32'h18, ins(32'h1c), 32'h1c, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, ins(32'h20), 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    pin(0, 5, "A_count_before_reset");
    idle(1'b0, 1'b0);
    #1 RESET = 1'b0;
    #2 RESET = 1'b1;
    pin(0, 0, "A_count_after_reset");
    idle(1'b0, 1'b0);
    pin(1, 1, "A_enq_ready_after_reset");
    idle(1'b0, 1'b0);

    // Wrap-around: fill 8, drain 6, refill 6, then drain 8 in order.
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, ins(32'h100 + 8*i), 32'h100 + 8*i,
                 ins(32'h104 + 8*i), 32'h104 + 8*i, 1'b0, 1'b0, 1'b0);
    end
    pin(3, 32'h100, "B_first_pop_pc0");
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, ins(32'h120 + 8*i), 32'h120 + 8*i,
                 ins(32'h124 + 8*i), 32'h124 + 8*i, 1'b0, 1'b0, 1'b0);
    end
    pin(0, 8, "B_count_full");
    cyc(2'b11, ins(32'h999), 32'h999, ins(32'h99c), 32'h99c, 1'b0, 1'b0, 1'b0);
    pin(1, 0, "B_enq_ready_full");
    idle(1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      pin(3, 32'h118 + 8*d, "B_drain_pc0");
      idle(1'b1, 1'b0);
    end
    pin(2, 0, "B_empty_valid");
    idle(1'b1, 1'b0);

    // Compaction with simultaneous enqueue and dequeue.
    cyc(2'b11, ins(32'h300), 32'h300, ins(32'h304), 32'h304, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, ins(32'h308), 32'h308, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    pin(3, 32'h300, "C_head_pc0");
    cyc(2'b10, 32'hdeadbeef, 32'hdeadbeef, ins(32'h200), 32'h200, 1'b1, 1'b0, 1'b0);
    pin(0, 2, "C_count2");
    idle(1'b0, 1'b0);
    pin(4, 32'h200, "C_compacted_pc1");
    idle(1'b1, 1'b0);

    // Syscall serialisation with a clean bubble window.
    cyc(2'b11, ADDU, 32'h400, SYS, 32'h404, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, ADDU, 32'h408, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    pin(2, 1, "D_c0_valid");   idle(1'b1, 1'b0);
    pin(6, SYS, "D_c1_instr"); idle(1'b1, 1'b0);
    pin(5, 1, "D_c2_hold");    idle(1'b1, 1'b0);
    pin(2, 0, "D_c3_valid");   idle(1'b1, 1'b0);
    pin(5, 1, "D_c4_hold");    idle(1'b1, 1'b0);
    pin(5, 1, "D_c5_hold");    idle(1'b1, 1'b0);
    pin(3, 32'h408, "D_c6_pc0"); idle(1'b1, 1'b0);
    pin(5, 0, "D_c7_hold");    idle(1'b1, 1'b0);

    // Stall inside the bubble window stretches it; enqueue still accepted.
    cyc(2'b11, SYS, 32'h500, ADDU, 32'h504, 1'b0, 1'b0, 1'b0);
    pin(2, 1, "E_c0_valid");   idle(1'b1, 1'b0);
    pin(5, 1, "E_c1_hold");    idle(1'b1, 1'b0);
    pin(0, 1, "E_c2_count");   idle(1'b1, 1'b1);
    pin(0, 1, "E_c3_count");
    cyc(2'b11, ins(32'h508), 32'h508, ins(32'h50c), 32'h50c, 1'b1, 1'b1, 1'b0);
    pin(0, 3, "E_c4_count");   idle(1'b1, 1'b0);
    pin(5, 1, "E_c5_hold");    idle(1'b1, 1'b0);
    pin(5, 1, "E_c6_hold");    idle(1'b1, 1'b0);
    pin(3, 32'h504, "E_c7_pc0"); idle(1'b1, 1'b0);
    pin(3, 32'h50c, "E_c8_pc0"); idle(1'b1, 1'b0);

    // Flush with a same-cycle enqueue, then flush during a stalled bubble.
    cyc(2'b11, ins(32'h600), 32'h600, ins(32'h604), 32'h604, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, ins(32'h608), 32'h608, ins(32'h60c), 32'h60c, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, ins(32'h610), 32'h610, ins(32'h614), 32'h614, 1'b0, 1'b0, 1'b0);
    pin(3, 32'h600, "F_flush_cycle_pc0");
    cyc(2'b11, ins(32'h900), 32'h900, ins(32'h904), 32'h904, 1'b1, 1'b0, 1'b1);
    pin(0, 0, "F_count_after_flush");
    idle(1'b0, 1'b0);
    cyc(2'b11, SYS, 32'h700, ADDU, 32'h704, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    pin(5, 1, "F_hold_before_flush");
    cyc(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    pin(5, 0, "F_hold_after_flush");
    cyc(2'b11, ins(32'h800), 32'h800, ins(32'h804), 32'h804, 1'b0, 1'b0, 1'b0);
    pin(3, 32'h800, "F_restart_pc0");
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Parametrised, multi-lane instruction buffer between Fetch and Decode. Generalises the current single-instruction fetch→ID latch for the out-of-order front end.
- Accepts up to LANES instructions per cycle and presents up to LANES oldest instructions in order to Decode.
- Absorbs fetch/decode rate mismatch, supports branch-redirect flush, and serialises syscalls with a configurable bubble window.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2*LANES.
- LANES, 2, enqueue/dequeue lanes per cycle; 1 to 4.
- SYS_BUBBLES, 4, idle dequeue cycles after a syscall leaves; 1 to 7.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Enq_Valid_IN  in  LANES  per-lane instruction valid from Fetch.
- Enq_Instr_IN  in  32*LANES  instructions; lane k occupies bits [32k+31:32k].
- Enq_PC_IN  in  32*LANES  PC per lane, same packing.
- Enq_Ready_OUT  out  1  queue can accept a full LANES group this cycle.
- Deq_Valid_OUT  out  LANES  per-lane valid to Decode; always a contiguous prefix from lane 0.
- Deq_Instr_OUT  out  32*LANES  head instructions; lane 0 is the oldest.
- Deq_PC_OUT  out  32*LANES  head PCs.
- Deq_Ready_IN  in  1  Decode consumes every lane whose Deq_Valid_OUT is high.
- STALL_IN  in  1  memory/back-end stall; blocks dequeue only.
- Flush_IN  in  1  redirect/misprediction flush.
- Count_OUT  out  CNT_W  current occupancy.
- SYS_Hold_OUT  out  1  syscall bubble window is active.

Behaviour:
- Reset (RESET low, asynchronous):
  - head = tail = count = 0; bubble counter = 0.
  - Enq_Ready_OUT = 1, Deq_Valid_OUT = 0, Count_OUT = 0, SYS_Hold_OUT = 0.
  - Deq_Instr_OUT and Deq_PC_OUT = 0.
  - Storage contents are don't-care.
- Storage: circular array of {instr, pc}. Head and tail pointers wrap modulo DEPTH.
- Enqueue:
  - Enq_Ready_OUT = (DEPTH - count >= LANES), computed from the registered count only; no same-cycle credit from a dequeue.
  - When Enq_Ready_OUT is high, each valid lane is written at tail + (number of valid lanes below it).
  - Non-contiguous valid masks are compacted in lane order.
  - tail advances by popcount(Enq_Valid_IN).
  - When Enq_Ready_OUT is low, Enq_Valid_IN is ignored and Fetch must hold.
- Dequeue is first-word-fall-through with zero latency: Deq_* are combinational from the entries at head..head+LANES-1.
- Deq_Valid_OUT[k] = 1 iff all of the following hold:
  - k < count;
  - bubble counter == 0;
  - no lane j < k holds a syscall (instr == 32'h0000000c);
  - if lane k holds a syscall, then k == 0.
  - Result: a syscall always dequeues alone in lane 0.
- Pop occurs when Deq_Ready_IN && !STALL_IN. Head advances by popcount(Deq_Valid_OUT).
- Count update: count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue are legal.
- Syscall serialisation:
  - When a syscall pops, the bubble counter loads SYS_BUBBLES.
  - The counter decrements each cycle while nonzero and STALL_IN is low; it holds while STALL_IN is high.
  - SYS_Hold_OUT = (bubble counter != 0).
  - Enqueue continues during the bubble window.
- Flush_IN (synchronous): head = tail = count = 0, bubble counter = 0.
  - Any enqueue in the same cycle is dropped.
  - Deq outputs in the flush cycle still reflect pre-flush state, but no pop is performed.
  - Flush takes priority over STALL_IN.
- Empty: Deq_Valid_OUT = 0; Deq_Ready_IN has no effect.
- Full: Enq_Ready_OUT = 0; dequeue still operates.
- Unused Deq lanes drive 0 data.

Test Plan:
- Reset mid-traffic: fill 5 entries, pulse RESET low between edges → all outputs immediately at reset values, Count_OUT = 0, Enq_Ready_OUT = 1.
- Wrap-around: DEPTH=8, LANES=2; enqueue 4 pairs, dequeue 3 pairs, enqueue 3 more pairs (PCs 0x100+4i) → Count_OUT = 8, Enq_Ready_OUT = 0; drain order is PC 0x118..0x134 with no gaps.
- Compaction plus simultaneous enq/deq: count = 3, Enq_Valid = 2'b10 (PC 0x200), Deq_Ready = 1 → 2 popped, 1 written, Count_OUT = 2; PC 0x200 sits directly behind the remaining entry.
- Syscall: queue holds {addu, 0xc, addu}; Deq_Ready held high → cycle 0 lane 0 only (addu); cycle 1 lane 0 = 0xc alone; SYS_Hold_OUT high for 4 cycles with Deq_Valid = 0; final addu appears on cycle 6.
- STALL during bubble: STALL_IN high for 2 cycles inside the window → window stretches to 6 cycles; enqueues still accepted.
- Flush with enqueue: count = 6, Flush_IN = 1 and Enq_Valid = 2'b11 in the same cycle → next cycle Count_OUT = 0, Deq_Valid = 0, SYS_Hold_OUT = 0.
